uart_rx: RTL and testbench

//  UART receive path, paired with the team's UART transmitter (same frame: 1 start, WIDTH_WORD data LSB-first, CANT_BIT_STOP stop).

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Definitions shared by the UART receive path and its paired transmitter:
// FSM state encodings, the fixed 16x oversampling ratio, the tick index of
// the start-bit midpoint and the default frame geometry.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int OVERSAMPLE        = 16;
  localparam int MID_START_TICK    = 7;
  localparam int DEF_WIDTH_WORD    = 8;
  localparam int DEF_CANT_BIT_STOP = 2;

  // One-hot receiver states
  typedef enum logic [3:0] {
    ESPERA = 4'b0001,
    START  = 4'b0010,
    READ   = 4'b0100,
    STOP   = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser that brings an asynchronous level into the i_clock
// domain. Both flops load RST_VAL during reset.
// Ports:
//   i_clock  system clock
//   i_reset  synchronous, active-low reset
//   i_d      asynchronous input level
//   o_q      synchronised level (two clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, WIDTH_WORD data bits (LSB first), CANT_BIT_STOP
// stop bits, sampled with a 16x oversampling tick.
// Optional feature macro: UART_RX_FRAMING_ERR_EN (adds o_framing_error).
// Ports:
//   i_clock          system clock
//   i_reset          synchronous, active-low reset
//   i_rate           oversampling tick enable, 16 pulses per bit
//   i_bit_rx         serial line, idle high, asynchronous
//   o_data_out       last complete received word
//   o_rx_done        one-cycle strobe, o_data_out just updated
//   o_framing_error  (macro only) last frame had a zero stop sample
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WIDTH_WORD    = DEF_WIDTH_WORD,
  parameter int CANT_BIT_STOP = DEF_CANT_BIT_STOP
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rate,
  input  logic                  i_bit_rx,
  output logic [WIDTH_WORD-1:0] o_data_out,
  output logic                  o_rx_done
`ifdef UART_RX_FRAMING_ERR_EN
  ,
  output logic                  o_framing_error
`endif
);

  localparam int BIT_W  = $clog2(WIDTH_WORD + 1);
  localparam int STOP_W = $clog2(CANT_BIT_STOP + 1);

  localparam logic [3:0]        TICK_MID  = 4'(MID_START_TICK);
  localparam logic [3:0]        TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]        TICK_ONE  = 4'd1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH_WORD - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(CANT_BIT_STOP - 1);
  localparam logic [STOP_W-1:0] STOP_ONE  = STOP_W'(1);

  logic rx_s;

  rx_state_e             state_q, state_d;
  logic [3:0]            tick_q,  tick_d;
  logic [BIT_W-1:0]      bit_q,   bit_d;
  logic [STOP_W-1:0]     stop_q,  stop_d;
  logic [WIDTH_WORD-1:0] shift_q, shift_d;
  logic [WIDTH_WORD-1:0] data_q,  data_d;
  logic                  done_q,  done_d;
`ifdef UART_RX_FRAMING_ERR_EN
  logic                  stop_bad_q, stop_bad_d;
  logic                  ferr_q,     ferr_d;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_bit_rx),
    .o_q     (rx_s)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ESPERA;
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
      stop_bad_q <= 1'b0;
      ferr_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef UART_RX_FRAMING_ERR_EN
      stop_bad_q <= stop_bad_d;
      ferr_q     <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;   // strobe lasts only the cycle after the final stop sample
`ifdef UART_RX_FRAMING_ERR_EN
    stop_bad_d = stop_bad_q;
    ferr_d     = ferr_q;
`endif
    if (i_rate) begin
      case (state_q)
        ESPERA: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          // Re-check the line at the start-bit midpoint to reject glitches
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? ESPERA : READ;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        READ: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[WIDTH_WORD-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              stop_d  = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (stop_q == STOP_LAST) begin
              stop_d  = '0;
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = ESPERA;
`ifdef UART_RX_FRAMING_ERR_EN
              ferr_d     = stop_bad_q | ~rx_s;
              stop_bad_d = 1'b0;
`endif
            end else begin
              stop_d = stop_q + STOP_ONE;
`ifdef UART_RX_FRAMING_ERR_EN
              stop_bad_d = stop_bad_q | ~rx_s;
`endif
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        default: begin
          // Recover from an illegal encoding
          state_d = ESPERA;
          tick_d  = '0;
        end
      endcase
    end
  end

  assign o_data_out = data_q;
  assign o_rx_done  = done_q;
`ifdef UART_RX_FRAMING_ERR_EN
  assign o_framing_error = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives serial frames into uart_rx with a 1-in-4 oversampling tick and
// compares every delivered word against a queue of expected frames.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int W  = 8;
  localparam int NS = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         rate  = 1'b0;
  logic         rx    = 1'b1;
  logic [W-1:0] dout;
  logic         done;
`ifdef UART_RX_FRAMING_ERR_EN
  logic         ferr;
`endif

  always #5 clk = ~clk;

  uart_rx #(.WIDTH_WORD(W), .CANT_BIT_STOP(NS)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_rate     (rate),
    .i_bit_rx   (rx),
    .o_data_out (dout),
    .o_rx_done  (done)
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    .o_framing_error (ferr)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Oversampling tick: one clock high every four clocks, gated by rate_en
  bit rate_en  = 1'b1;
  int rate_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      rate     = rate_en && (rate_cnt == 3);
      rate_cnt = (rate_cnt + 1) % 4;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a frame is expected to deliver its data byte, flagged
  // bad when any of its stop bits was driven low.
  typedef struct {
    logic [W-1:0] data;
    bit           bad;
  } exp_t;
  exp_t expq[$];
  int   sent    = 0;
  int   strobes = 0;
  int   t_fall  = 0;
  int   t_done  = 0;

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      strobes++;
      t_done = cyc;
      check_eq("strobe_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        $display("rx word 0x%02h expected 0x%02h at cycle %0d", dout, e.data, cyc);
        check_eq("rx_data", 32'(dout), 32'(e.data));
`ifdef UART_RX_FRAMING_ERR_EN
        check_eq("framing_error", 32'(ferr), 32'(e.bad));
`endif
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rate) @(posedge clk);
    end
  endtask

  task automatic idle_ticks(input int n);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // stop_vals[i] is the level of stop bit i; abort_bit >= 0 pulses reset at
  // the start of that frame bit; freeze_bit >= 0 stops the tick for 100
  // clocks at the start of that frame bit.
  task automatic send_frame(input logic [W-1:0] data, input logic [NS-1:0] stop_vals,
                            input int abort_bit, input int freeze_bit);
    logic [W+NS:0] bits;
    logic [W-1:0]  hold;
    int            s0;
    bits = {stop_vals, data, 1'b0};
    if (abort_bit < 0) begin
      exp_t e;
      e.data = data;
      e.bad  = (stop_vals != {NS{1'b1}});
      expq.push_back(e);
      sent++;
    end
    for (int b = 0; b < W + NS + 1; b++) begin
      @(negedge clk);
      if (b == abort_bit) begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      rx = bits[b];
      if (b == 0) t_fall = cyc;
      if (b == freeze_bit) begin
        rate_en = 1'b0;
        hold    = dout;
        s0      = strobes;
        repeat (100) @(negedge clk);
        check_eq("freeze_data_held", 32'(dout), 32'(hold));
        check_eq("freeze_no_strobe", 32'(strobes), 32'(s0));
        rate_en = 1'b1;
      end
      wait_ticks(16);
    end
  endtask

  initial begin
    logic [W-1:0] hold;
    logic [W-1:0] rnd;
    logic [NS-1:0] sv;
    int lat;

    repeat (5) @(negedge clk);
    check_eq("reset_data", 32'(dout), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
`ifdef UART_RX_FRAMING_ERR_EN
    check_eq("reset_ferr", 32'(ferr), 32'd0);
`endif
    rst_n = 1'b1;
    idle_ticks(20);

    // Single frame and strobe latency (mid last stop bit = 672 clocks after the fall)
    send_frame(8'hA5, 2'b11, -1, -1);
    idle_ticks(4);
    check_eq("a5_strobes", 32'(strobes), 32'd1);
    lat = t_done - t_fall;
    $display("A5 strobe latency %0d cycles", lat);
    check_eq("a5_latency_window", 32'(lat >= 664 && lat <= 688), 32'd1);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 2'b11, -1, -1);
    send_frame(8'hFF, 2'b11, -1, -1);
    idle_ticks(4);
    check_eq("b2b_strobes", 32'(strobes), 32'd3);

    // Short glitch on idle line
    hold = dout;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(3);
    idle_ticks(40);
    check_eq("glitch_no_strobe", 32'(strobes), 32'd3);
    check_eq("glitch_data_held", 32'(dout), 32'(hold));

    // Reset mid-data, then a clean frame
    send_frame(8'h3C, 2'b11, 4, -1);
    @(negedge clk);
    check_eq("abort_data_cleared", 32'(dout), 32'd0);
    idle_ticks(20);
    check_eq("abort_no_strobe", 32'(strobes), 32'd3);
    send_frame(8'h81, 2'b11, -1, -1);
    idle_ticks(4);
    check_eq("after_abort_strobes", 32'(strobes), 32'd4);

    // Second stop bit low, then a good frame
    send_frame(8'h55, 2'b01, -1, -1);
    idle_ticks(20);
    send_frame(8'h96, 2'b11, -1, -1);
    idle_ticks(4);
    check_eq("stop_err_strobes", 32'(strobes), 32'd6);

    // Tick frozen mid-frame
    send_frame(8'hC3, 2'b11, -1, 5);
    idle_ticks(4);
    check_eq("freeze_strobes", 32'(strobes), 32'd7);

    // Random frames; only the first stop bit may be low so the line never
    // lingers low past the end of a frame
    for (int i = 0; i < 12; i++) begin
      rnd = W'($urandom);
      sv  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      send_frame(rnd, sv, -1, -1);
      if ($urandom_range(0, 1) == 1) idle_ticks($urandom_range(1, 20));
    end
    idle_ticks(4);

    for (int k = 0; k < 2000 && expq.size() != 0; k++) @(negedge clk);
    check_eq("queue_drained", 32'(expq.size()), 32'd0);
    check_eq("total_strobes", 32'(strobes), 32'(sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
